// File: rtl/step_sequencer_pkg.sv
// Shared types, sizes, default timing constants and small helpers for the
// 4-track, 16-step sequencer.
package step_sequencer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  localparam int unsigned NUM_TRACKS = 4;
  localparam int unsigned NUM_STEPS  = 16;

  localparam int unsigned DEF_STEP_TICKS = 12500000;
  localparam int unsigned DEF_GATE_TICKS = 6250000;
  localparam int unsigned DEF_HALF_P1    = 47778;
  localparam int unsigned DEF_HALF_P2    = 42566;
  localparam int unsigned DEF_HALF_P3    = 37922;
  localparam int unsigned DEF_HALF_P4    = 31888;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic logic [NUM_TRACKS-1:0] step_pattern(
    input logic [NUM_STEPS-1:0] n1,
    input logic [NUM_STEPS-1:0] n2,
    input logic [NUM_STEPS-1:0] n3,
    input logic [NUM_STEPS-1:0] n4,
    input logic [3:0]           idx
  );
    return {n4[idx], n3[idx], n2[idx], n1[idx]};
  endfunction

  // Track 1 (bit 0) has the highest priority, so scan downwards and keep
  // the last hit.
  function automatic logic [1:0] lowest_active(input logic [NUM_TRACKS-1:0] act);
    logic [1:0] v;
    v = 2'd0;
    for (int i = NUM_TRACKS - 1; i >= 0; i--) begin
      if (act[i]) v = 2'(i);
    end
    return v;
  endfunction

endpackage

// File: rtl/step_sequencer_tone_gen.sv
// Square-wave generator: toggles every half_period cycles, held low while
// clear is asserted.
module step_sequencer_tone_gen #(
  parameter int unsigned HALF_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [HALF_W-1:0] half_period,
  output logic              tone
);

  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              tone_q, tone_d;

  always_comb begin
    cnt_d  = cnt_q + HALF_W'(1);
    tone_d = tone_q;
    if (clear) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (cnt_q == half_period - HALF_W'(1)) begin
      cnt_d  = '0;
      tone_d = ~tone_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/step_sequencer.sv
// Step sequencer: tempo divider, 16-step index, mute/priority arbitration
// and a gated square-wave tone for the winning track.
module step_sequencer
  import step_sequencer_pkg::*;
#(
  parameter int unsigned STEP_TICKS = DEF_STEP_TICKS,
  parameter int unsigned GATE_TICKS = DEF_GATE_TICKS,
  parameter int unsigned HALF_P1    = DEF_HALF_P1,
  parameter int unsigned HALF_P2    = DEF_HALF_P2,
  parameter int unsigned HALF_P3    = DEF_HALF_P3,
  parameter int unsigned HALF_P4    = DEF_HALF_P4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [NUM_STEPS-1:0]  note1,
  input  logic [NUM_STEPS-1:0]  note2,
  input  logic [NUM_STEPS-1:0]  note3,
  input  logic [NUM_STEPS-1:0]  note4,
  input  logic [NUM_TRACKS-1:0] mute,
  output logic                  running,
  output logic [3:0]            step,
  output logic                  step_strobe,
  output logic                  bar_strobe,
  output logic [NUM_TRACKS-1:0] active,
  output logic [1:0]            voice,
  output logic                  gate,
  output logic                  tone
);

  localparam int unsigned TICK_W = $clog2(STEP_TICKS);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(STEP_TICKS - 1);
  localparam int unsigned HALF_W = $clog2(max4(HALF_P1, HALF_P2, HALF_P3, HALF_P4) + 1);

  seq_state_e            state_q, state_d;
  logic [3:0]            step_q, step_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic                  step_strobe_q, step_strobe_d;
  logic                  bar_strobe_q, bar_strobe_d;
  logic [NUM_TRACKS-1:0] active_q, active_d;
  logic [1:0]            voice_q, voice_d;
  logic                  gate_q, gate_d;
  logic [3:0]            next_step;
  logic [HALF_W-1:0]     half_d;
  logic                  tone_clear;

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    tick_d        = tick_q;
    step_strobe_d = 1'b0;
    bar_strobe_d  = 1'b0;
    active_d      = active_q;
    next_step     = step_q + 4'd1;

    if (state_q == IDLE) begin
      if (start && !stop) begin
        state_d       = RUN;
        step_d        = 4'd0;
        tick_d        = '0;
        step_strobe_d = 1'b1;
        bar_strobe_d  = 1'b1;
        active_d      = step_pattern(note1, note2, note3, note4, 4'd0) & ~mute;
      end
    end else begin
      if (stop) begin
        state_d  = IDLE;
        step_d   = 4'd0;
        tick_d   = '0;
        active_d = '0;
      end else if (tick_q == LAST_TICK) begin
        tick_d        = '0;
        step_d        = next_step;
        step_strobe_d = 1'b1;
        bar_strobe_d  = (next_step == 4'd0);
        active_d      = step_pattern(note1, note2, note3, note4, next_step) & ~mute;
      end else begin
        tick_d = tick_q + TICK_W'(1);
      end
    end

    // Gate and voice are derived from next-state values so they line up
    // with the registered step/active outputs.
    gate_d  = (state_d == RUN) && (active_d != '0) && (32'(tick_d) < GATE_TICKS);
    voice_d = lowest_active(active_d);
  end

  always_comb begin
    case (voice_d)
      2'd0:    half_d = HALF_W'(HALF_P1);
      2'd1:    half_d = HALF_W'(HALF_P2);
      2'd2:    half_d = HALF_W'(HALF_P3);
      default: half_d = HALF_W'(HALF_P4);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      step_q        <= 4'd0;
      tick_q        <= '0;
      step_strobe_q <= 1'b0;
      bar_strobe_q  <= 1'b0;
      active_q      <= '0;
      voice_q       <= 2'd0;
      gate_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      tick_q        <= tick_d;
      step_strobe_q <= step_strobe_d;
      bar_strobe_q  <= bar_strobe_d;
      active_q      <= active_d;
      voice_q       <= voice_d;
      gate_q        <= gate_d;
    end
  end

  // Tone restarts at every step boundary so each note begins low.
  assign tone_clear = !gate_d || step_strobe_d;

  step_sequencer_tone_gen #(
    .HALF_W(HALF_W)
  ) u_tone_gen (
    .clk        (clk),
    .reset      (reset),
    .clear      (tone_clear),
    .half_period(half_d),
    .tone       (tone)
  );

  assign running     = (state_q == RUN);
  assign step        = step_q;
  assign step_strobe = step_strobe_q;
  assign bar_strobe  = bar_strobe_q;
  assign active      = active_q;
  assign voice       = voice_q;
  assign gate        = gate_q;

endmodule
